tcdm_bank_ts_adapter: RTL and testbench

TCDM_BANK_TS_ADAPTER -- requirements
Module: tcdm_bank_ts_adapter

---
 rtl/hci_package.sv | 9 +
 rtl/tcdm_bank_ts_adapter.sv | 106 ++++++++++
 tb/tb_tcdm_bank_ts_adapter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hci_package.sv
// Constants shared by the HCI/TCDM bank-side adapters.
package hci_package;

  localparam int unsigned HCI_MAX_DW = 1024;

  // Written back by the second half of a test-and-set; sliced down to the bank width.
  localparam logic [HCI_MAX_DW-1:0] TS_SET_PATTERN = '1;

endpackage

// File: rtl/tcdm_bank_ts_adapter.sv
// TCDM bank port to single-port SRAM adapter with atomic test-and-set:
// a TS read returns the old word and then spends one stall cycle writing all ones.
module tcdm_bank_ts_adapter
  import hci_package::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 13,
  parameter int unsigned IW = 8,
  parameter int unsigned BW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [AW-1:0] add_i,
  input  logic          wen_i,
  input  logic          ts_i,
  input  logic [DW-1:0] data_i,
  input  logic [BW-1:0] be_i,
  input  logic [IW-1:0] id_i,
  output logic          r_valid_o,
  output logic [DW-1:0] r_data_o,
  output logic [IW-1:0] r_id_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-3:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [BW-1:0] mem_be_o,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic {
    IDLE  = 1'b0,
    TS_WR = 1'b1
  } state_e;

  state_e        state_q;
  logic [AW-3:0] ts_addr_q;
  logic          rd_sel_q;
  logic          grant;

  // The bank is word addressed; the byte offset never reaches the SRAM.
  logic unused_byte_offset;
  assign unused_byte_offset = ^add_i[1:0];

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    grant       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = ~wen_i;
    mem_addr_o  = add_i[AW-1:2];
    mem_wdata_o = data_i;
    mem_be_o    = be_i;
    unique case (state_q)
      IDLE: begin
        grant     = req_i & ~clear_i;
        mem_req_o = grant;
      end
      TS_WR: begin
        // A soft clear here drops the pending set-to-ones write.
        mem_req_o   = ~clear_i;
        mem_we_o    = 1'b1;
        mem_addr_o  = ts_addr_q;
        mem_wdata_o = TS_SET_PATTERN[DW-1:0];
        mem_be_o    = '1;
      end
      default: ;
    endcase
  end

  assign gnt_o = grant;

  // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ts_addr_q <= '0;
      rd_sel_q  <= 1'b0;
      r_valid_o <= 1'b0;
      r_id_o    <= '0;
    end else begin
      r_valid_o <= grant;
      rd_sel_q  <= grant & wen_i;
      if (grant) r_id_o <= id_i;
      if (clear_i) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (grant && wen_i && ts_i) begin
              state_q   <= TS_WR;
              ts_addr_q <= add_i[AW-1:2];
            end
          end
          TS_WR:   state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Read data arrives from the macro in the response cycle; writes answer with zero.
  assign r_data_o = rd_sel_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_tcdm_bank_ts_adapter.sv
// Self-checking bench: directed vector table, reset-during-TS sequence and
// random traffic against a word-array reference model of the bank.
module tb_tcdm_bank_ts_adapter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 13;
  localparam int unsigned IW = 8;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned NW = 1 << (AW - 2);

  logic          clk_i = 1'b0;
  logic          rst_ni, clear_i, req_i, gnt_o, wen_i, ts_i;
  logic [AW-1:0] add_i;
  logic [DW-1:0] data_i;
  logic [BW-1:0] be_i;
  logic [IW-1:0] id_i;
  logic          r_valid_o;
  logic [DW-1:0] r_data_o;
  logic [IW-1:0] r_id_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-3:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  tcdm_bank_ts_adapter #(.DW(DW), .AW(AW), .IW(IW), .BW(BW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .wen_i(wen_i), .ts_i(ts_i), .data_i(data_i), .be_i(be_i), .id_i(id_i),
    .r_valid_o(r_valid_o), .r_data_o(r_data_o), .r_id_o(r_id_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata)
  );

  // Single-port SRAM: read data valid the cycle after the request.
  logic [DW-1:0] sram [NW];
  logic          mem_init_done = 1'b0;
  // NOTE: the backing store is filled by a one-shot loop on the first clock, never by reset; SRAM contents are not reset.
  always @(posedge clk_i) begin
    if (!mem_init_done) begin
      for (int i = 0; i < NW; i++) sram[i] <= '0;
      sram[8]       <= 32'h5;
      mem_init_done <= 1'b1;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr_o];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          clr, req, wen, ts;
    logic [AW-1:0] add;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic [IW-1:0] id;
    logic          e_gnt, e_mreq, e_mwe;
    logic [AW-3:0] e_maddr;
    logic [DW-1:0] e_mwdata;
    logic [BW-1:0] e_mbe;
    logic          e_rvalid;
    logic [DW-1:0] e_rdata;
    logic [IW-1:0] e_rid;
  } vec_t;

  function automatic vec_t mk(
    input logic clr, req, wen, ts, input logic [AW-1:0] add, input logic [DW-1:0] data,
    input logic [BW-1:0] be, input logic [IW-1:0] id,
    input logic e_gnt, e_mreq, e_mwe, input logic [AW-3:0] e_maddr,
    input logic [DW-1:0] e_mwdata, input logic [BW-1:0] e_mbe,
    input logic e_rvalid, input logic [DW-1:0] e_rdata, input logic [IW-1:0] e_rid);
    vec_t v;
    v.clr = clr; v.req = req; v.wen = wen; v.ts = ts; v.add = add; v.data = data;
    v.be = be; v.id = id; v.e_gnt = e_gnt; v.e_mreq = e_mreq; v.e_mwe = e_mwe;
    v.e_maddr = e_maddr; v.e_mwdata = e_mwdata; v.e_mbe = e_mbe;
    v.e_rvalid = e_rvalid; v.e_rdata = e_rdata; v.e_rid = e_rid;
    return v;
  endfunction

  task automatic drive(input logic clr, req, wen, ts, input logic [AW-1:0] add,
                       input logic [DW-1:0] data, input logic [BW-1:0] be, input logic [IW-1:0] id);
    clear_i = clr; req_i = req; wen_i = wen; ts_i = ts;
    add_i = add; data_i = data; be_i = be; id_i = id;
  endtask

  vec_t          vecs[$];
  logic [DW-1:0] ref_mem [NW];
  logic          holding, exp_gnt, resp_due, ts_reserved;
  logic [AW-3:0] word, ts_word;
  logic [DW-1:0] resp_data;
  logic [IW-1:0] resp_id;
  int            n_grants, n_resp;

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 1, 0, '0, '0, '0, '0);

    // clr req wen ts add data be id | gnt mreq mwe maddr mwdata mbe | rvalid rdata rid
    vecs.push_back(mk(0,1,0,0,'h010,'hDEADBEEF,'hF,'h11, 1,1,1,'h004,'hDEADBEEF,'hF, 0,0,0));
    vecs.push_back(mk(0,1,1,0,'h010,0,'hF,'h22,          1,1,0,'h004,0,'hF, 1,0,'h11));
    vecs.push_back(mk(0,1,1,1,'h020,0,'hF,'h33,          1,1,0,'h008,0,'hF, 1,'hDEADBEEF,'h22));
    vecs.push_back(mk(0,1,1,0,'h020,0,'hF,'h44,          0,1,1,'h008,'hFFFFFFFF,'hF, 1,'h5,'h33));
    vecs.push_back(mk(0,1,1,0,'h020,0,'hF,'h44,          1,1,0,'h008,0,'hF, 0,0,0));
    vecs.push_back(mk(0,1,0,0,'h020,'h7,'hF,'h45,        1,1,1,'h008,'h7,'hF, 1,'hFFFFFFFF,'h44));
    vecs.push_back(mk(0,1,1,1,'h020,0,'hF,'h55,          1,1,0,'h008,0,'hF, 1,0,'h45));
    vecs.push_back(mk(0,1,1,1,'h020,0,'hF,'h66,          0,1,1,'h008,'hFFFFFFFF,'hF, 1,'h7,'h55));
    vecs.push_back(mk(0,1,1,1,'h020,0,'hF,'h66,          1,1,0,'h008,0,'hF, 0,0,0));
    vecs.push_back(mk(0,0,1,0,'h000,0,'hF,'h00,          0,1,1,'h008,'hFFFFFFFF,'hF, 1,'hFFFFFFFF,'h66));
    vecs.push_back(mk(0,1,0,0,'h030,'h12345678,'hF,'h70, 1,1,1,'h00C,'h12345678,'hF, 0,0,0));
    vecs.push_back(mk(0,1,1,1,'h030,0,'hF,'h71,          1,1,0,'h00C,0,'hF, 1,0,'h70));
    vecs.push_back(mk(1,0,1,0,'h000,0,'hF,'h00,          0,0,0,0,0,0, 1,'h12345678,'h71));
    vecs.push_back(mk(0,1,1,0,'h030,0,'hF,'h72,          1,1,0,'h00C,0,'hF, 0,0,0));
    vecs.push_back(mk(0,0,1,0,'h000,0,'hF,'h00,          0,0,0,0,0,0, 1,'h12345678,'h72));
    vecs.push_back(mk(1,1,1,0,'h010,0,'hF,'h80,          0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,1,0,'h000,0,'hF,'h00,          0,0,0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0,'h010,'hAABBCCDD,'h3,'h90, 1,1,1,'h004,'hAABBCCDD,'h3, 0,0,0));
    vecs.push_back(mk(0,1,1,0,'h010,0,'hF,'h91,          1,1,0,'h004,0,'hF, 1,0,'h90));
    vecs.push_back(mk(0,0,1,0,'h000,0,'hF,'h00,          0,0,0,0,0,0, 1,'hDEADCCDD,'h91));
    vecs.push_back(mk(0,1,0,0,'h1FFF,'h0BADF00D,'hF,'hA0, 1,1,1,'h7FF,'h0BADF00D,'hF, 0,0,0));
    vecs.push_back(mk(0,1,1,0,'h1FFC,0,'hF,'hA1,         1,1,0,'h7FF,0,'hF, 1,0,'hA0));
    vecs.push_back(mk(0,0,1,0,'h000,0,'hF,'h00,          0,0,0,0,0,0, 1,'h0BADF00D,'hA1));

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset gnt", gnt_o, 0);
    check("reset mem_req", mem_req_o, 0);
    check("reset r_valid", r_valid_o, 0);
    check("reset r_data", r_data_o, 0);
    check("reset r_id", r_id_o, 0);
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk_i); #1;
      drive(vecs[i].clr, vecs[i].req, vecs[i].wen, vecs[i].ts,
            vecs[i].add, vecs[i].data, vecs[i].be, vecs[i].id);
      @(negedge clk_i);
      check($sformatf("vec%0d gnt", i), gnt_o, vecs[i].e_gnt);
      check($sformatf("vec%0d mem_req", i), mem_req_o, vecs[i].e_mreq);
      if (vecs[i].e_mreq) begin
        check($sformatf("vec%0d mem_we", i), mem_we_o, vecs[i].e_mwe);
        check($sformatf("vec%0d mem_addr", i), mem_addr_o, vecs[i].e_maddr);
        check($sformatf("vec%0d mem_wdata", i), mem_wdata_o, vecs[i].e_mwdata);
        check($sformatf("vec%0d mem_be", i), mem_be_o, vecs[i].e_mbe);
      end
      check($sformatf("vec%0d r_valid", i), r_valid_o, vecs[i].e_rvalid);
      if (vecs[i].e_rvalid) begin
        check($sformatf("vec%0d r_data", i), r_data_o, vecs[i].e_rdata);
        check($sformatf("vec%0d r_id", i), r_id_o, vecs[i].e_rid);
      end
    end
    check("ts word set to ones", sram[8], 32'hFFFFFFFF);
    check("cleared ts left word", sram[12], 32'h12345678);

    // Reset asserted while the TS write is being presented.
    @(posedge clk_i); #1; drive(0, 1, 0, 0, 'h040, 'h42, 'hF, 'hC0);
    @(posedge clk_i); #1; drive(0, 1, 1, 1, 'h040, 0, 'hF, 'hC1);
    @(posedge clk_i); #1; drive(0, 0, 1, 0, 'h000, 0, 'hF, 'h00);
    @(negedge clk_i);
    check("ts write presented", mem_req_o, 1);
    check("ts response valid", r_valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid-ts reset gnt", gnt_o, 0);
    check("mid-ts reset mem_req", mem_req_o, 0);
    check("mid-ts reset r_valid", r_valid_o, 0);
    check("mid-ts reset r_data", r_data_o, 0);
    check("mid-ts reset r_id", r_id_o, 0);
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    check("mid-ts reset memory kept", sram[16], 32'h42);

    // Random traffic: the model sees the bank as an array of words plus one reserved write slot.
    for (int i = 0; i < NW; i++) ref_mem[i] = sram[i];
    holding = 0; resp_due = 0; ts_reserved = 0; ts_word = '0;
    resp_data = '0; resp_id = '0; n_grants = 0; n_resp = 0;
    for (int cyc = 0; cyc < 40000 && n_grants < 10000; cyc++) begin
      @(posedge clk_i); #1;
      if (!holding && $urandom_range(99) < 70) begin
        int kind;
        holding = 1;
        kind    = $urandom_range(3);
        wen_i   = (kind == 0 || kind == 2);
        ts_i    = (kind >= 2);
        add_i   = AW'(32'h100 + ($urandom_range(7) << 2) + $urandom_range(3));
        data_i  = $urandom;
        be_i    = BW'($urandom_range(15));
        id_i    = IW'($urandom);
      end
      req_i   = holding;
      clear_i = ($urandom_range(99) < 3);
      @(negedge clk_i);
      exp_gnt = req_i && !clear_i && !ts_reserved;
      check("rnd gnt", gnt_o, exp_gnt);
      check("rnd r_valid", r_valid_o, resp_due);
      if (resp_due) begin
        check("rnd r_data", r_data_o, resp_data);
        check("rnd r_id", r_id_o, resp_id);
      end
      if (r_valid_o) n_resp++;
      if (ts_reserved && !clear_i) ref_mem[ts_word] = '1;
      ts_reserved = 0;
      resp_due    = exp_gnt;
      if (exp_gnt) begin
        n_grants++;
        holding = 0;
        word    = add_i[AW-1:2];
        resp_id = id_i;
        if (!wen_i) begin
          for (int b = 0; b < BW; b++)
            if (be_i[b]) ref_mem[word][8*b +: 8] = data_i[8*b +: 8];
          resp_data = '0;
        end else begin
          resp_data = ref_mem[word];
          if (ts_i) begin
            ts_reserved = 1;
            ts_word     = word;
          end
        end
      end
    end
    check("rnd grant budget reached", n_grants >= 10000, 1);

    @(posedge clk_i); #1; drive(0, 0, 1, 0, '0, '0, '0, '0);
    @(negedge clk_i);
    check("drain r_valid", r_valid_o, resp_due);
    if (resp_due) begin
      check("drain r_data", r_data_o, resp_data);
      check("drain r_id", r_id_o, resp_id);
    end
    if (r_valid_o) n_resp++;
    if (ts_reserved) ref_mem[ts_word] = '1;
    @(posedge clk_i); #1;
    check("one response per grant", n_resp, n_grants);
    for (int w = 64; w < 72; w++) check($sformatf("rnd mem word %0d", w), sram[w], ref_mem[w]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
